// File: rtl/mul_div_x.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_x
// Purpose  : Iterative MUL/MLI/DIV/DVI/MOD/MDI unit producing q and EX (DCPU).
// Revision : 1.0  initial release
// ============================================================================
module mul_div_x #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] EX,
  output logic             ex_we
);

  localparam int c_cw = $clog2(2 * WIDTH);
  localparam logic [c_cw-1:0] c_n_short = c_cw'(WIDTH - 1);
  localparam logic [c_cw-1:0] c_n_long  = c_cw'(2 * WIDTH - 1);
  localparam logic [c_cw-1:0] c_one     = c_cw'(1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_calc = 2'd1;
  localparam logic [1:0] c_fix  = 2'd2;

  localparam logic [1:0] c_kind_mul = 2'b00;
  localparam logic [1:0] c_kind_div = 2'b01;
  localparam logic [1:0] c_kind_mod = 2'b10;

  logic [1:0]         r_state;
  logic [1:0]         r_kind;
  logic               r_sign;
  logic               r_short;
  logic [c_cw-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0] r_sh;
  logic               r_done;
  logic               r_ex_we;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_ex;

  logic               w_in_mul;
  logic               w_in_div;
  logic               w_in_mod;
  logic               w_in_sgn;
  logic               w_short;
  logic               w_sign;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_mag_a;

  assign w_in_mul = (op[2:1] == c_kind_mul);
  assign w_in_div = (op[2:1] == c_kind_div);
  assign w_in_mod = (op[2:1] == c_kind_mod);
  assign w_in_sgn = op[0];
  assign w_mag_b  = (w_in_sgn && b[WIDTH-1]) ? -b : b;
  assign w_mag_a  = (w_in_sgn && a[WIDTH-1]) ? -a : a;
  assign w_short  = !(w_in_mul || ((w_in_div || w_in_mod) && (a != '0)));
  // MDI takes the sign of the dividend only; MLI/DVI the xor of both signs.
  assign w_sign   = w_in_sgn && (w_in_mod ? b[WIDTH-1] : (b[WIDTH-1] ^ a[WIDTH-1]));

  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;

  assign w_add     = {1'b0, r_acc} + {1'b0, (r_sh[0] ? r_opnd : {WIDTH{1'b0}})};
  assign w_shifted = {r_acc, r_sh[2*WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, r_opnd};
  assign w_ge      = !w_trial[WIDTH];

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fix_q;
  logic [WIDTH-1:0]   w_fix_ex;
  logic               w_fix_we;

  assign w_prod = r_sign ? -{r_acc, r_sh[WIDTH-1:0]} : {r_acc, r_sh[WIDTH-1:0]};

  // Division negates the integer and fraction halves separately (truncation toward zero).
  always_comb begin
    w_fix_q  = '0;
    w_fix_ex = '0;
    w_fix_we = 1'b0;
    if (r_short) begin
      w_fix_we = (r_kind == c_kind_div);
    end else begin
      case (r_kind)
        c_kind_mul: begin
          w_fix_q  = w_prod[WIDTH-1:0];
          w_fix_ex = w_prod[2*WIDTH-1:WIDTH];
          w_fix_we = 1'b1;
        end
        c_kind_div: begin
          w_fix_q  = r_sign ? -r_sh[2*WIDTH-1:WIDTH] : r_sh[2*WIDTH-1:WIDTH];
          w_fix_ex = r_sign ? -r_sh[WIDTH-1:0] : r_sh[WIDTH-1:0];
          w_fix_we = 1'b1;
        end
        c_kind_mod: begin
          w_fix_q  = r_sign ? -r_acc : r_acc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_kind  <= '0;
      r_sign  <= 1'b0;
      r_short <= 1'b0;
      r_cnt   <= '0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_sh    <= '0;
      r_done  <= 1'b0;
      r_ex_we <= 1'b0;
      r_q     <= '0;
      r_ex    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            r_kind  <= op[2:1];
            r_sign  <= w_sign;
            r_short <= w_short;
            r_cnt   <= w_in_div ? c_n_long : c_n_short;
            r_opnd  <= w_in_mul ? w_mag_b : w_mag_a;
            r_acc   <= '0;
            // Multiply shifts the multiplier out of the low half; divide shifts the dividend out of the top.
            r_sh    <= w_in_mul ? {{WIDTH{1'b0}}, w_mag_a} : {w_mag_b, {WIDTH{1'b0}}};
            r_state <= w_short ? c_fix : c_calc;
          end
        end
        c_calc: begin
          if (r_kind == c_kind_mul) begin
            r_acc           <= w_add[WIDTH:1];
            r_sh[WIDTH-1:0] <= {w_add[0], r_sh[WIDTH-1:1]};
          end else begin
            r_acc <= w_ge ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
            r_sh  <= {r_sh[2*WIDTH-2:0], w_ge};
          end
          if (r_cnt == '0) begin
            r_state <= c_fix;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        c_fix: begin
          r_done  <= 1'b1;
          r_q     <= w_fix_q;
          r_ex    <= w_fix_ex;
          r_ex_we <= w_fix_we;
          r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign ready = (r_state == c_idle);
  assign busy  = ~ready;
  assign done  = r_done;
  assign q     = r_q;
  assign EX    = r_ex;
  assign ex_we = r_ex_we;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_x.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mul_div_x
// Purpose  : Scoreboard bench for mul_div_x at WIDTH=16.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_x;
  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] a     = '0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] EX;
  logic         ex_we;

  mul_div_x #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .b(b), .a(a),
    .ready(ready), .busy(busy), .done(done), .q(q), .EX(EX), .ex_we(ex_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] b;
    logic [W-1:0] a;
    logic [W-1:0] q;
    logic [W-1:0] ex;
    logic         we;
    logic         chk_ex;
    int           lat;
  } vec_t;

  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t lit(input logic [2:0] o, input logic [W-1:0] bb, input logic [W-1:0] aa,
                               input logic [W-1:0] qq, input logic [W-1:0] ee, input logic we,
                               input logic chk, input int lat);
    vec_t v;
    v.op = o; v.b = bb; v.a = aa; v.q = qq; v.ex = ee; v.we = we; v.chk_ex = chk; v.lat = lat;
    return v;
  endfunction

  // Reference results from plain wide arithmetic on magnitudes.
  function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] bb, input logic [W-1:0] aa);
    vec_t v;
    logic [63:0] mb, ma, r;
    logic sg, s;
    v.op = o; v.b = bb; v.a = aa; v.q = '0; v.ex = '0; v.we = 1'b0; v.chk_ex = 1'b1; v.lat = 1;
    sg = o[0];
    mb = {48'd0, bb};
    ma = {48'd0, aa};
    if (sg && bb[15]) mb = 64'h10000 - mb;
    if (sg && aa[15]) ma = 64'h10000 - ma;
    case (o)
      3'd0, 3'd1: begin
        r = mb * ma;
        s = sg & (bb[15] ^ aa[15]);
        if (s) r = -r;
        v.q = r[15:0]; v.ex = r[31:16]; v.we = 1'b1; v.lat = 17;
      end
      3'd2, 3'd3: begin
        v.we = 1'b1;
        if (aa != '0) begin
          r = (mb << 16) / ma;
          s = sg & (bb[15] ^ aa[15]);
          v.q  = r[31:16];
          v.ex = r[15:0];
          if (s) begin
            v.q  = -r[31:16];
            v.ex = -r[15:0];
          end
          v.lat = 33;
        end
      end
      3'd4, 3'd5: begin
        v.chk_ex = 1'b0;
        if (aa != '0) begin
          r = mb % ma;
          if (sg && bb[15]) r = -r;
          v.q = r[15:0]; v.lat = 17;
        end
      end
      default: ;
    endcase
    return v;
  endfunction

  function automatic string nm(input vec_t v);
    return $sformatf("op%0d b=%h a=%h", v.op, v.b, v.a);
  endfunction

  task automatic send(input vec_t v);
    @(negedge clk);
    op = v.op; b = v.b; a = v.a; start = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset ready got=%b want=1", ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got=%b want=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done got=%b want=0", done); end
    n_vec++; if (q !== 16'h0) begin n_err++; $display("FAIL reset q got=%h want=0000", q); end
    n_vec++; if (EX !== 16'h0) begin n_err++; $display("FAIL reset EX got=%h want=0000", EX); end
    n_vec++; if (ex_we !== 1'b0) begin n_err++; $display("FAIL reset ex_we got=%b want=0", ex_we); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul;
    vec_t vs[$];
    vec_t e;
    int lat;
    vs.push_back(lit(3'd0, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b1, 1'b1, 17));
    vs.push_back(lit(3'd1, 16'hFFFF, 16'h0002, 16'hFFFE, 16'hFFFF, 1'b1, 1'b1, 17));
    vs.push_back(lit(3'd1, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b1, 1'b1, 17));
    for (int k = 0; k < 4; k++) vs.push_back(model(3'(k & 1), 16'($urandom), 16'($urandom)));
    foreach (vs[i]) begin
      send(vs[i]); wait_done(lat); e = exp_q.pop_front();
      n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL mul %s latency got=%0d want=%0d", nm(e), lat, e.lat); end
      n_vec++; if (q !== e.q) begin n_err++; $display("FAIL mul %s q got=%h want=%h", nm(e), q, e.q); end
      if (e.chk_ex) begin n_vec++; if (EX !== e.ex) begin n_err++; $display("FAIL mul %s EX got=%h want=%h", nm(e), EX, e.ex); end end
      n_vec++; if (ex_we !== e.we) begin n_err++; $display("FAIL mul %s ex_we got=%b want=%b", nm(e), ex_we, e.we); end
    end
  endtask

  task automatic test_div;
    vec_t vs[$];
    vec_t e;
    int lat;
    vs.push_back(lit(3'd2, 16'h0007, 16'h0002, 16'h0003, 16'h8000, 1'b1, 1'b1, 33));
    vs.push_back(lit(3'd3, 16'hFFF9, 16'h0002, 16'hFFFD, 16'h8000, 1'b1, 1'b1, 33));
    vs.push_back(lit(3'd3, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 1'b1, 33));
    for (int k = 0; k < 4; k++) vs.push_back(model(3'(2 + (k & 1)), 16'($urandom), 16'($urandom_range(1, 16'hFFFF))));
    foreach (vs[i]) begin
      send(vs[i]); wait_done(lat); e = exp_q.pop_front();
      n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL div %s latency got=%0d want=%0d", nm(e), lat, e.lat); end
      n_vec++; if (q !== e.q) begin n_err++; $display("FAIL div %s q got=%h want=%h", nm(e), q, e.q); end
      if (e.chk_ex) begin n_vec++; if (EX !== e.ex) begin n_err++; $display("FAIL div %s EX got=%h want=%h", nm(e), EX, e.ex); end end
      n_vec++; if (ex_we !== e.we) begin n_err++; $display("FAIL div %s ex_we got=%b want=%b", nm(e), ex_we, e.we); end
    end
  endtask

  task automatic test_mod_zero;
    vec_t vs[$];
    vec_t e;
    int lat;
    vs.push_back(lit(3'd2, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1));
    vs.push_back(lit(3'd6, 16'h1234, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1, 1));
    vs.push_back(lit(3'd5, 16'hFFF9, 16'h0010, 16'hFFF9, 16'h0000, 1'b0, 1'b0, 17));
    vs.push_back(lit(3'd4, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1));
    vs.push_back(lit(3'd7, 16'h00FF, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b1, 1));
    for (int k = 0; k < 4; k++) vs.push_back(model(3'(4 + (k & 1)), 16'($urandom), 16'($urandom_range(1, 300))));
    foreach (vs[i]) begin
      send(vs[i]); wait_done(lat); e = exp_q.pop_front();
      n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL mod %s latency got=%0d want=%0d", nm(e), lat, e.lat); end
      n_vec++; if (q !== e.q) begin n_err++; $display("FAIL mod %s q got=%h want=%h", nm(e), q, e.q); end
      if (e.chk_ex) begin n_vec++; if (EX !== e.ex) begin n_err++; $display("FAIL mod %s EX got=%h want=%h", nm(e), EX, e.ex); end end
      n_vec++; if (ex_we !== e.we) begin n_err++; $display("FAIL mod %s ex_we got=%b want=%b", nm(e), ex_we, e.we); end
    end
  endtask

  task automatic test_start_held;
    vec_t e;
    int dones = 0;
    int lat = -1;
    logic [W-1:0] q_s = '0;
    logic [W-1:0] ex_s = '0;
    @(negedge clk);
    op = 3'd2; b = 16'h0007; a = 16'h0002; start = 1'b1;
    exp_q.push_back(lit(3'd2, 16'h0007, 16'h0002, 16'h0003, 16'h8000, 1'b1, 1'b1, 33));
    @(posedge clk); #1;
    op = 3'd0; b = 16'h0100; a = 16'h0003;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (lat < 0) begin lat = i; q_s = q; ex_s = EX; end
      end
      if (i == 32) start = 1'b0;
    end
    e = exp_q.pop_front();
    n_vec++; if (dones != 1) begin n_err++; $display("FAIL held done_count got=%0d want=1", dones); end
    n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL held latency got=%0d want=%0d", lat, e.lat); end
    n_vec++; if (q_s !== e.q) begin n_err++; $display("FAIL held q got=%h want=%h", q_s, e.q); end
    n_vec++; if (ex_s !== e.ex) begin n_err++; $display("FAIL held EX got=%h want=%h", ex_s, e.ex); end
  endtask

  task automatic test_back_to_back;
    vec_t vs[$];
    vec_t e;
    int lat;
    vs.push_back(lit(3'd0, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b1, 1'b1, 17));
    vs.push_back(lit(3'd5, 16'hFFF9, 16'h0010, 16'hFFF9, 16'h0000, 1'b0, 1'b0, 17));
    foreach (vs[i]) begin
      send(vs[i]); wait_done(lat); e = exp_q.pop_front();
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b %s ready_with_done got=%b want=1", nm(e), ready); end
      n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL b2b %s latency got=%0d want=%0d", nm(e), lat, e.lat); end
      n_vec++; if (q !== e.q) begin n_err++; $display("FAIL b2b %s q got=%h want=%h", nm(e), q, e.q); end
      n_vec++; if (ex_we !== e.we) begin n_err++; $display("FAIL b2b %s ex_we got=%b want=%b", nm(e), ex_we, e.we); end
    end
  endtask

  task automatic test_reset_mid;
    vec_t e;
    int lat;
    int dones = 0;
    send(lit(3'd2, 16'h1234, 16'h0007, 16'h0000, 16'h0000, 1'b1, 1'b1, 33));
    exp_q.delete();
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rstmid ready got=%b want=1", ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid busy got=%b want=0", busy); end
    n_vec++; if (q !== 16'h0) begin n_err++; $display("FAIL rstmid q got=%h want=0000", q); end
    n_vec++; if (EX !== 16'h0) begin n_err++; $display("FAIL rstmid EX got=%h want=0000", EX); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_vec++; if (dones != 0) begin n_err++; $display("FAIL rstmid stray_done got=%0d want=0", dones); end
    send(lit(3'd0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b1, 1'b1, 17));
    wait_done(lat); e = exp_q.pop_front();
    n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL rstmid mul latency got=%0d want=%0d", lat, e.lat); end
    n_vec++; if (q !== e.q) begin n_err++; $display("FAIL rstmid mul q got=%h want=%h", q, e.q); end
    n_vec++; if (EX !== e.ex) begin n_err++; $display("FAIL rstmid mul EX got=%h want=%h", EX, e.ex); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_mod_zero;
    test_start_held;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mul_div_x.md
Name: mul_div_X

Overview:
- Parametrised iterative multiply/divide unit for the DCPU datapath.
- Companion to the combinational add/sub/EX unit.
- Executes MUL, MLI, DIV, DVI, MOD and MDI, producing the result `q` and the overflow word `EX` with DCPU semantics, generalised to `WIDTH` bits.
- Multi-cycle with a start/done handshake. The control unit stalls on `busy`.

Parameters:
- WIDTH, 16, operand/result/EX width in bits (must be >= 4)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when ready=1
- op  in  3  0=MUL 1=MLI 2=DIV 3=DVI 4=MOD 5=MDI 6,7=illegal
- b  in  WIDTH  first operand (dividend / multiplicand)
- a  in  WIDTH  second operand (divisor / multiplier)
- ready  out  1  idle, able to accept start
- busy  out  1  operation in progress (equals ~ready)
- done  out  1  one-cycle pulse, result valid
- q  out  WIDTH  result
- EX  out  WIDTH  overflow/fraction word
- ex_we  out  1  EX should be written (valid with done)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - Outputs: ready=1, busy=0, done=0, q=0, EX=0, ex_we=0.
  - An operation in progress is abandoned. No done pulse occurs after release.
- Operand capture:
  - b, a and op are registered on the accepting edge (IDLE and start=1).
  - Later input changes have no effect.
  - start while busy is ignored, not queued.
- State machine:
  - IDLE -> CALC on an accepted start.
  - CALC runs N iterations (one per cycle), then goes to FIX.
  - FIX applies the sign correction, registers q/EX/ex_we and asserts done for one cycle, then returns to IDLE. ready=1 in the same cycle as done.
  - start is accepted back-to-back with done (in IDLE on the following cycle).
- Iteration count N:
  - MUL/MLI: N=WIDTH (shift-add on magnitudes).
  - DIV/DVI: N=2*WIDTH (restoring division of {|b|, WIDTH'b0} by |a|).
  - MOD/MDI: N=WIDTH (restoring division of |b| by |a|, remainder kept).
- Latency: done is high N+1 cycles after the accepting edge.
- Short paths (take IDLE -> FIX, done 1 cycle after accept, CALC skipped):
  - Divisor zero (ops 2-5): q=0. EX=0 with ex_we=1 for DIV/DVI; ex_we=0 for MOD/MDI.
  - Illegal op 6/7: q=0, EX=0, ex_we=0.
- Results (all arithmetic mod 2^WIDTH; P is 2*WIDTH bits):
  - MUL: P = b*a unsigned; q = P[W-1:0], EX = P[2W-1:W], ex_we=1.
  - MLI: as MUL with b and a signed. Magnitude product is negated if the signs differ.
  - DIV: Q = floor(b*2^W / a); q = Q[2W-1:W], EX = Q[W-1:0], ex_we=1.
  - DVI:
    - Q = floor(|b|*2^W / |a|), s = sign(b) xor sign(a).
    - q = s ? -Q[2W-1:W] : Q[2W-1:W], i.e. truncation toward zero.
    - EX = low W bits of (s ? -Q : Q).
    - ex_we=1.
    - Overflow (most-negative / -1) wraps: q=most-negative.
  - MOD: q = b % a, ex_we=0.
  - MDI: q = |b| % |a| with the sign of b; ex_we=0.
- q, EX and ex_we hold their last values until the next FIX. done is the only pulse.

Test Plan:
- WIDTH=16. MUL b=0x1234 a=0x0100 -> done exactly 17 cycles after accept, q=0x3400, EX=0x0012, ex_we=1.
- Signed corners:
  - MLI b=0xFFFF a=0x0002 -> q=0xFFFE, EX=0xFFFF.
  - MLI b=0x8000 a=0x8000 -> q=0x0000, EX=0x4000.
- Division:
  - DIV b=7 a=2 -> done after 33 cycles, q=0x0003, EX=0x8000.
  - DVI b=0xFFF9 a=0x0002 -> q=0xFFFD, EX=0x8000.
  - DVI b=0x8000 a=0xFFFF -> q=0x8000, EX=0x0000.
- Modulo and zero divisor:
  - MDI b=0xFFF9 a=0x0010 -> q=0xFFF9, ex_we=0, latency 17.
  - MOD b=7 a=0 -> q=0, done 1 cycle after accept.
  - DIV b=5 a=0 -> q=0, EX=0, ex_we=1.
  - op=6 -> q=0, ex_we=0, done after 1 cycle.
- Handshake:
  - start held high during a DIV -> exactly one done, operands of the first request only.
  - start on the cycle after done -> accepted, second result correct.
- Reset mid-operation:
  - rst_n low at cycle 10 of a DIV -> ready=1, q=0, EX=0 immediately (async).
  - No done pulse after release.
  - A following MUL 3*5 -> q=15, EX=0.
